store_align_unit: RTL and testbench

- Store-side counterpart of the load result extender: the core presents register data, byte address and store size (SB/SH/SW funct3); the unit drives word-aligned, byte-strobed write beats to the data-memory bus.
- Stores crossing a word boundary are split into two bus beats.
- Sits between the execute stage and the data-memory port; the core holds the pipeline while the unit is busy.

---
 rtl/store_pkg.sv | 20 ++
 rtl/store_lane_shift.sv | 47 ++++
 rtl/store_align_unit.sv | 129 ++++++++++++
 tb/tb_store_align_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types and constants for the store alignment datapath.
package store_pkg;

   localparam int RegBitsDefault = 32;
   localparam int BeBits         = RegBitsDefault / 8;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      ERR   = 2'd3
   } state_t;

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane placement: masks register data to the store size and
// shifts data and strobes into a double-width window so that a store
// crossing a word boundary lands partly in the upper word.
module store_lane_shift
   import store_pkg::*;
#(
   parameter int RegBits = RegBitsDefault
) (
   input  logic [RegBits-1:0]   data,
   input  logic [2:0]           size,
   input  logic [1:0]           offset,
   output logic [2*RegBits-1:0] shiftData,
   output logic [RegBits/4-1:0] shiftBe,
   output logic                 illegal
);

   localparam int ByteLanes = RegBits / 8;

   logic [RegBits-1:0]   maskedData;
   logic [ByteLanes-1:0] sizeMask;

   // Keep only the bytes the store size covers and build the matching strobe mask.
   always_comb begin
      maskedData = '0;
      sizeMask   = '0;
      illegal    = 1'b0;
      case (size)
         SB: begin
            maskedData[7:0] = data[7:0];
            sizeMask[0]     = 1'b1;
         end
         SH: begin
            maskedData[15:0] = data[15:0];
            sizeMask[1:0]    = 2'b11;
         end
         SW: begin
            maskedData = data;
            sizeMask   = '1;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign shiftData = {{RegBits{1'b0}}, maskedData} << {offset, 3'b000};
   assign shiftBe   = {{ByteLanes{1'b0}}, sizeMask} << offset;

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a register store into one or two word-aligned,
// byte-strobed write beats on the data-memory bus, and reports completion.
module store_align_unit
   import store_pkg::*;
#(
   parameter int RegBits  = RegBitsDefault,
   parameter int AddrBits = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [AddrBits-1:0]   addr_i,
   input  logic [RegBits-1:0]    data_i,
   input  logic [2:0]            store_size_i,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [AddrBits-1:0]   mem_addr_o,
   output logic [RegBits-1:0]    mem_wdata_o,
   output logic [RegBits/8-1:0]  mem_be_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int ByteLanes = RegBits / 8;

   state_t                 state;
   logic [AddrBits-1:0]    beatAddr;
   logic [2*RegBits-1:0]   dataReg;
   logic [2*ByteLanes-1:0] beReg;
   logic                   doneReg;
   logic                   errReg;

   logic [2*RegBits-1:0]   shiftData;
   logic [2*ByteLanes-1:0] shiftBe;
   logic                   illegal;
   logic                   reqFire;
   logic                   beatFire;

   store_lane_shift #(
      .RegBits (RegBits)
   ) laneShift (
      .data      (data_i),
      .size      (store_size_i),
      .offset    (addr_i[1:0]),
      .shiftData (shiftData),
      .shiftBe   (shiftBe),
      .illegal   (illegal)
   );

   assign req_ready_o = (state == IDLE);
   assign reqFire     = req_valid_i && req_ready_o;
   assign beatFire    = mem_valid_o && mem_ready_i;
   assign done_o      = doneReg;
   assign err_o       = errReg;

   // Sequencer: capture the request, walk through the beats, pulse completion on return to IDLE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         beatAddr <= '0;
         dataReg  <= '0;
         beReg    <= '0;
         doneReg  <= 1'b0;
         errReg   <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         errReg  <= 1'b0;
         case (state)
            IDLE: begin
               if (reqFire) begin
                  beatAddr <= {addr_i[AddrBits-1:2], 2'b00};
                  dataReg  <= shiftData;
                  beReg    <= shiftBe;
                  state    <= illegal ? ERR : BEAT0;
               end
            end
            BEAT0: begin
               if (beatFire) begin
                  if (|beReg[2*ByteLanes-1:ByteLanes]) begin
                     state <= BEAT1;
                  end else begin
                     state   <= IDLE;
                     doneReg <= 1'b1;
                  end
               end
            end
            BEAT1: begin
               if (beatFire) begin
                  state   <= IDLE;
                  doneReg <= 1'b1;
               end
            end
            ERR: begin
               state   <= IDLE;
               doneReg <= 1'b1;
               errReg  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus outputs come straight from state so they stay frozen until the beat is accepted.
   always_comb begin
      mem_valid_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      case (state)
         BEAT0: begin
            mem_valid_o = 1'b1;
            mem_addr_o  = beatAddr;
            mem_wdata_o = dataReg[RegBits-1:0];
            mem_be_o    = beReg[ByteLanes-1:0];
         end
         BEAT1: begin
            mem_valid_o = 1'b1;
            mem_addr_o  = beatAddr + AddrBits'(4);
            mem_wdata_o = dataReg[2*RegBits-1:RegBits];
            mem_be_o    = beReg[2*ByteLanes-1:ByteLanes];
         end
         default: begin
            mem_valid_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: directed cases with literal expectations plus a
// randomized run compared every cycle against a byte-level reference model.
module tb_store_align_unit;

   logic        clk_i;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [2:0]  store_size_i;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        done_o;
   logic        err_o;

   int compareCount  = 0;
   int mismatchCount = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } beat_t;

   beat_t beatQ[$];
   logic  errPending = 1'b0;
   logic  expDone    = 1'b0;
   logic  expErr     = 1'b0;
   logic  nextDone;
   logic  nextErr;

   store_align_unit #(
      .RegBits  (32),
      .AddrBits (32)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .store_size_i (store_size_i),
      .mem_valid_o  (mem_valid_o),
      .mem_ready_i  (mem_ready_i),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Place each stored byte individually into the word it lands in; a new word starts a new beat.
   function automatic void buildBeats(input logic [31:0] a, input logic [31:0] d, input int nBytes);
      beat_t       cur;
      logic [31:0] byteAddr;
      logic [31:0] wordAddr;
      int          lane;
      cur = '0;
      for (int i = 0; i < nBytes; i++) begin
         byteAddr = a + 32'(i);
         wordAddr = byteAddr & 32'hFFFF_FFFC;
         lane     = int'(byteAddr & 32'd3);
         if (i == 0) begin
            cur.addr = wordAddr;
         end else if (wordAddr != cur.addr) begin
            beatQ.push_back(cur);
            cur      = '0;
            cur.addr = wordAddr;
         end
         cur.wdata[lane*8 +: 8] = d[i*8 +: 8];
         cur.be[lane]           = 1'b1;
      end
      beatQ.push_back(cur);
   endfunction

   // Reference model: a queue of outstanding beats, an error marker and the completion flags.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beatQ.delete();
         errPending = 1'b0;
         expDone    = 1'b0;
         expErr     = 1'b0;
      end else begin
         nextDone = 1'b0;
         nextErr  = 1'b0;
         if (errPending) begin
            errPending = 1'b0;
            nextDone   = 1'b1;
            nextErr    = 1'b1;
         end else if (beatQ.size() != 0) begin
            if (mem_ready_i) begin
               beatQ.delete(0);
               if (beatQ.size() == 0) nextDone = 1'b1;
            end
         end else if (req_valid_i) begin
            case (store_size_i)
               3'b000:  buildBeats(addr_i, data_i, 1);
               3'b001:  buildBeats(addr_i, data_i, 2);
               3'b010:  buildBeats(addr_i, data_i, 4);
               default: errPending = 1'b1;
            endcase
         end
         expDone = nextDone;
         expErr  = nextErr;
      end
   end

   // Every cycle out of reset, compare all DUT outputs against the model.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         checkOutput("model req_ready", 32'(req_ready_o), 32'(beatQ.size() == 0 && !errPending));
         checkOutput("model mem_valid", 32'(mem_valid_o), 32'(beatQ.size() != 0));
         if (beatQ.size() != 0) begin
            checkOutput("model mem_addr", mem_addr_o, beatQ[0].addr);
            checkOutput("model mem_wdata", mem_wdata_o, beatQ[0].wdata);
            checkOutput("model mem_be", 32'(mem_be_o), 32'(beatQ[0].be));
         end
         checkOutput("model done", 32'(done_o), 32'(expDone));
         checkOutput("model err", 32'(err_o), 32'(expErr));
      end
   end

   // Present one request for a single cycle; caller is at a negedge with the unit idle.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      req_valid_i  = 1'b1;
      addr_i       = a;
      data_i       = d;
      store_size_i = sz;
      @(negedge clk_i);
      req_valid_i  = 1'b0;
   endtask

   task automatic checkBeat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      checkOutput({tag, " valid"}, 32'(mem_valid_o), 32'd1);
      checkOutput({tag, " addr"}, mem_addr_o, a);
      checkOutput({tag, " wdata"}, mem_wdata_o, d);
      checkOutput({tag, " be"}, 32'(mem_be_o), 32'(be));
      checkOutput({tag, " req_ready"}, 32'(req_ready_o), 32'd0);
   endtask

   // Directed cases first, then a randomized run, then the summary.
   initial begin
      rst_ni       = 1'b0;
      req_valid_i  = 1'b0;
      addr_i       = '0;
      data_i       = '0;
      store_size_i = '0;
      mem_ready_i  = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("reset req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("reset mem_valid", 32'(mem_valid_o), 32'd0);
      checkOutput("reset mem_addr", mem_addr_o, 32'd0);
      checkOutput("reset mem_wdata", mem_wdata_o, 32'd0);
      checkOutput("reset mem_be", 32'(mem_be_o), 32'd0);
      checkOutput("reset done", 32'(done_o), 32'd0);
      checkOutput("reset err", 32'(err_o), 32'd0);
      rst_ni      = 1'b1;
      mem_ready_i = 1'b1;
      @(negedge clk_i);

      $display("[TB] aligned SW");
      applyStimulus(32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
      checkBeat("sw beat0", 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
      @(negedge clk_i);
      checkOutput("sw done", 32'(done_o), 32'd1);
      checkOutput("sw err", 32'(err_o), 32'd0);
      checkOutput("sw valid after", 32'(mem_valid_o), 32'd0);
      checkOutput("sw req_ready after", 32'(req_ready_o), 32'd1);

      $display("[TB] SB top lane");
      applyStimulus(32'h0000_0103, 32'h1234_56A5, 3'b000);
      checkBeat("sb beat0", 32'h0000_0100, 32'hA500_0000, 4'b1000);
      @(negedge clk_i);
      checkOutput("sb done", 32'(done_o), 32'd1);

      $display("[TB] split SH");
      applyStimulus(32'h0000_0203, 32'h0000_1234, 3'b001);
      checkBeat("sh beat0", 32'h0000_0200, 32'h3400_0000, 4'b1000);
      @(negedge clk_i);
      checkBeat("sh beat1", 32'h0000_0204, 32'h0000_0012, 4'b0001);
      checkOutput("sh no early done", 32'(done_o), 32'd0);
      @(negedge clk_i);
      checkOutput("sh done", 32'(done_o), 32'd1);

      $display("[TB] split SW with bus stalls");
      mem_ready_i = 1'b0;
      applyStimulus(32'h0000_0102, 32'hAABB_CCDD, 3'b010);
      for (int i = 0; i < 3; i++) begin
         checkBeat("stall beat0", 32'h0000_0100, 32'hCCDD_0000, 4'b1100);
         @(negedge clk_i);
      end
      mem_ready_i = 1'b1;
      checkBeat("stall beat0 accept", 32'h0000_0100, 32'hCCDD_0000, 4'b1100);
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkBeat("stall beat1", 32'h0000_0104, 32'h0000_AABB, 4'b0011);
         @(negedge clk_i);
      end
      mem_ready_i = 1'b1;
      checkBeat("stall beat1 accept", 32'h0000_0104, 32'h0000_AABB, 4'b0011);
      @(negedge clk_i);
      checkOutput("stall done", 32'(done_o), 32'd1);
      checkOutput("stall req_ready", 32'(req_ready_o), 32'd1);

      $display("[TB] illegal size");
      applyStimulus(32'h0000_0300, 32'h5555_5555, 3'b011);
      checkOutput("illegal valid", 32'(mem_valid_o), 32'd0);
      checkOutput("illegal early done", 32'(done_o), 32'd0);
      checkOutput("illegal req_ready busy", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      checkOutput("illegal valid 2", 32'(mem_valid_o), 32'd0);
      checkOutput("illegal done", 32'(done_o), 32'd1);
      checkOutput("illegal err", 32'(err_o), 32'd1);
      @(negedge clk_i);
      checkOutput("illegal done clears", 32'(done_o), 32'd0);
      checkOutput("illegal err clears", 32'(err_o), 32'd0);

      $display("[TB] wrap and reset during second beat");
      applyStimulus(32'hFFFF_FFFE, 32'h1122_3344, 3'b010);
      checkBeat("wrap beat0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
      @(negedge clk_i);
      checkBeat("wrap beat1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
      #2;
      rst_ni = 1'b0;
      #1;
      checkOutput("async reset valid", 32'(mem_valid_o), 32'd0);
      checkOutput("async reset req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("async reset done", 32'(done_o), 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      checkOutput("post reset req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("post reset valid", 32'(mem_valid_o), 32'd0);
      checkOutput("post reset done", 32'(done_o), 32'd0);

      $display("[TB] randomized traffic");
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int r;
         req_valid_i  = 1'($urandom_range(0, 1));
         addr_i       = $urandom;
         data_i       = $urandom;
         r            = int'($urandom_range(0, 9));
         store_size_i = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
         mem_ready_i  = ($urandom_range(0, 3) != 0);
         @(negedge clk_i);
      end
      req_valid_i = 1'b0;
      mem_ready_i = 1'b1;
      repeat (6) @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
